rtc_timekeeper: RTL and testbench

//  Parametrised HH:MM:SS time-of-day counter; next generation of the team's free-running clock display.

---
 rtl/rtc_pkg.sv | 18 +
 rtl/rtc_prescaler.sv | 29 ++
 rtl/rtc_timekeeper.sv | 119 +++++++++++
 tb/tb_rtc_timekeeper.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared constants and the 12-hour display mapping for the time-of-day counter.
package rtc_pkg;

    localparam int unsigned SEC_MAX = 59;
    localparam int unsigned MIN_MAX = 59;
    localparam int unsigned MS_W    = 6;

    // Midnight and noon both display as 12.
    function automatic int unsigned to_12h(input int unsigned hour, input int unsigned hours_day);
        int unsigned half;
        half = hours_day / 2;
        if ((hour % half) == 0) begin
            return 12;
        end
        return hour % half;
    endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Divides the system clock down to a one-cycle tick every TICK_DIV enabled cycles.
module rtc_prescaler #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = run && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/rtc_timekeeper.sv
// HH:MM:SS time-of-day counter with validated load, alarm compare, day wrap and 12/24-h display.
module rtc_timekeeper
    import rtc_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned HOURS_DAY = 24,
    parameter int unsigned HW        = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic            mode_12h,
    input  logic            set_en,
    input  logic [HW-1:0]   set_h,
    input  logic [MS_W-1:0] set_m,
    input  logic [MS_W-1:0] set_s,
    input  logic            alm_wr,
    input  logic [HW-1:0]   alm_h,
    input  logic [MS_W-1:0] alm_m,
    input  logic            alm_en,
    output logic [HW-1:0]   hour,
    output logic [MS_W-1:0] min,
    output logic [MS_W-1:0] sec,
    output logic [HW-1:0]   hour_disp,
    output logic            pm,
    output logic            sec_pulse,
    output logic            day_wrap,
    output logic            alarm_hit,
    output logic            set_err
);

    localparam logic [HW-1:0]   HOUR_LAST = HW'(HOURS_DAY - 1);
    localparam logic [HW-1:0]   HALF_DAY  = HW'(HOURS_DAY / 2);
    localparam logic [MS_W-1:0] SEC_LAST  = MS_W'(SEC_MAX);
    localparam logic [MS_W-1:0] MIN_LAST  = MS_W'(MIN_MAX);

    logic            tick;
    logic            set_ok;
    logic [HW-1:0]   hour_nx;
    logic [MS_W-1:0] min_nx;
    logic [MS_W-1:0] sec_nx;
    logic            wrap_nx;
    logic [HW-1:0]   alm_hour;
    logic [HW-1:0]   alm_hour_nx;
    logic [MS_W-1:0] alm_min;
    logic [MS_W-1:0] alm_min_nx;

    assign set_ok = set_en && (set_h <= HOUR_LAST) && (set_m <= MIN_LAST) && (set_s <= SEC_LAST);

    // An accepted load restarts the second so the new time is held for a full tick period.
    rtc_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .run  (run),
        .clr  (set_ok),
        .tick (tick)
    );

    always_comb begin
        alm_hour_nx = alm_wr ? alm_h : alm_hour;
        alm_min_nx  = alm_wr ? alm_m : alm_min;
        hour_nx     = hour;
        min_nx      = min;
        sec_nx      = sec + MS_W'(1);
        wrap_nx     = 1'b0;
        if (sec == SEC_LAST) begin
            sec_nx = '0;
            min_nx = min + MS_W'(1);
            if (min == MIN_LAST) begin
                min_nx  = '0;
                hour_nx = hour + HW'(1);
                if (hour == HOUR_LAST) begin
                    hour_nx = '0;
                    wrap_nx = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hour      <= '0;
            min       <= '0;
            sec       <= '0;
            alm_hour  <= '0;
            alm_min   <= '0;
            sec_pulse <= 1'b0;
            day_wrap  <= 1'b0;
            alarm_hit <= 1'b0;
            set_err   <= 1'b0;
        end else begin
            sec_pulse <= 1'b0;
            day_wrap  <= 1'b0;
            alarm_hit <= 1'b0;
            set_err   <= set_en && !set_ok;
            alm_hour  <= alm_hour_nx;
            alm_min   <= alm_min_nx;
            if (set_ok) begin
                hour <= set_h;
                min  <= set_m;
                sec  <= set_s;
            end else if (tick) begin
                hour      <= hour_nx;
                min       <= min_nx;
                sec       <= sec_nx;
                sec_pulse <= 1'b1;
                day_wrap  <= wrap_nx;
                alarm_hit <= alm_en && (sec_nx == '0) && (hour_nx == alm_hour_nx)
                             && (min_nx == alm_min_nx);
            end
        end
    end

    assign hour_disp = mode_12h ? HW'(to_12h(32'(hour), HOURS_DAY)) : hour;
    assign pm        = (hour >= HALF_DAY);

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Self-checking bench for rtc_timekeeper: seconds-of-day reference model, table and directed sequences.
module tb_rtc_timekeeper;

    localparam int unsigned TICK_DIV  = 4;
    localparam int unsigned HOURS_DAY = 24;
    localparam int unsigned HW        = 5;
    localparam int          DAY_SECS  = 24 * 3600;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0;
    logic          mode_12h = 1'b0;
    logic          set_en = 1'b0;
    logic [HW-1:0] set_h = '0;
    logic [5:0]    set_m = '0;
    logic [5:0]    set_s = '0;
    logic          alm_wr = 1'b0;
    logic [HW-1:0] alm_h = '0;
    logic [5:0]    alm_m = '0;
    logic          alm_en = 1'b0;
    logic [HW-1:0] hour;
    logic [5:0]    min;
    logic [5:0]    sec;
    logic [HW-1:0] hour_disp;
    logic          pm;
    logic          sec_pulse;
    logic          day_wrap;
    logic          alarm_hit;
    logic          set_err;
    logic [26:0]   dut_vec;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: time as seconds since midnight plus prescaler phase.
    int m_tod = 0;
    int m_ph = 0;
    int m_ah = 0;
    int m_am = 0;
    bit m_sp = 0;
    bit m_dw = 0;
    bit m_hit = 0;
    bit m_se = 0;

    rtc_timekeeper #(
        .TICK_DIV (TICK_DIV),
        .HOURS_DAY(HOURS_DAY),
        .HW       (HW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .mode_12h (mode_12h),
        .set_en   (set_en),
        .set_h    (set_h),
        .set_m    (set_m),
        .set_s    (set_s),
        .alm_wr   (alm_wr),
        .alm_h    (alm_h),
        .alm_m    (alm_m),
        .alm_en   (alm_en),
        .hour     (hour),
        .min      (min),
        .sec      (sec),
        .hour_disp(hour_disp),
        .pm       (pm),
        .sec_pulse(sec_pulse),
        .day_wrap (day_wrap),
        .alarm_hit(alarm_hit),
        .set_err  (set_err)
    );

    assign dut_vec = {hour, min, sec, hour_disp, pm, sec_pulse, day_wrap, alarm_hit, set_err};

    always #5 clk = ~clk;

    function automatic logic [26:0] model_out();
        int h;
        int d;
        h = m_tod / 3600;
        d = mode_12h ? (((h % 12) == 0) ? 12 : (h % 12)) : h;
        return {5'(h), 6'((m_tod / 60) % 60), 6'(m_tod % 60), 5'(d), (h >= 12), m_sp, m_dw, m_hit,
                m_se};
    endfunction

    task automatic model_reset();
        m_tod = 0; m_ph = 0; m_ah = 0; m_am = 0;
        m_sp = 0; m_dw = 0; m_hit = 0; m_se = 0;
    endtask

    task automatic model_edge();
        bit tk;
        bit ok;
        tk = run && (m_ph == TICK_DIV - 1);
        ok = set_en && (int'(set_h) < 24) && (int'(set_m) < 60) && (int'(set_s) < 60);
        m_sp = 0; m_dw = 0; m_hit = 0;
        m_se = set_en && !ok;
        if (alm_wr) begin
            m_ah = int'(alm_h);
            m_am = int'(alm_m);
        end
        if (ok) begin
            m_tod = int'(set_h) * 3600 + int'(set_m) * 60 + int'(set_s);
            m_ph = 0;
        end else begin
            if (run) m_ph = (m_ph + 1) % TICK_DIV;
            if (tk) begin
                m_tod = (m_tod + 1) % DAY_SECS;
                m_sp = 1;
                m_dw = (m_tod == 0);
                m_hit = alm_en && (m_ah < 24) && (m_am < 60) && (m_tod == m_ah * 3600 + m_am * 60);
            end
        end
    endtask

    task automatic check(input string name, input logic [26:0] act, input logic [26:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_n(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input string name);
        @(posedge clk);
        model_edge();
        #1;
        check(name, dut_vec, model_out());
        set_en = 1'b0;
        alm_wr = 1'b0;
    endtask

    task automatic do_set(input int h, input int m, input int s);
        set_h = HW'(h);
        set_m = 6'(m);
        set_s = 6'(s);
        set_en = 1'b1;
        cycle("set");
    endtask

    typedef struct {
        int h;
        bit m12;
        int disp;
        bit pm;
    } disp_vec_t;

    disp_vec_t tbl[10];

    initial begin
        int cnt;
        int snap;

        tbl[0] = '{0, 1, 12, 0};  tbl[1] = '{12, 1, 12, 1};
        tbl[2] = '{13, 1, 1, 1};  tbl[3] = '{0, 0, 0, 0};
        tbl[4] = '{12, 0, 12, 1}; tbl[5] = '{13, 0, 13, 1};
        tbl[6] = '{11, 1, 11, 0}; tbl[7] = '{23, 1, 11, 1};
        tbl[8] = '{1, 1, 1, 0};   tbl[9] = '{23, 0, 23, 1};

        // Reset state, both display modes
        #23;
        model_reset();
        check("reset", dut_vec, model_out());
        mode_12h = 1'b1;
        #1;
        check_n("reset_disp12", int'(hour_disp), 12);
        mode_12h = 1'b0;
        rst_n = 1'b1;

        // 1: one minute of free running
        run = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4 * 60; i++) begin
            cycle("t1_run");
            cnt += int'(sec_pulse);
        end
        check_n("t1_pulses", cnt, 60);
        check_n("t1_min", int'(min), 1);
        check_n("t1_sec", int'(sec), 0);

        // 2: day wrap
        do_set(23, 59, 58);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cycle("t2_wrap");
            cnt += int'(day_wrap);
        end
        check_n("t2_wrap_cnt", cnt, 1);
        check_n("t2_time", {int'(hour), int'(min), int'(sec)} == 0 ? 0 : 1, 0);

        // 3: rejected set, then accepted set coincident with a tick
        snap = m_tod;
        do_set(5, 60, 0);
        check_n("t3_set_err", int'(set_err), 1);
        check_n("t3_unchanged", m_tod, snap);
        for (int i = 0; i < 8 && m_ph != TICK_DIV - 1; i++) cycle("t3_align");
        check_n("t3_aligned", m_ph, TICK_DIV - 1);
        do_set(13, 5, 0);
        check_n("t3_nosp", int'(sec_pulse), 0);
        check_n("t3_time", int'(hour) * 3600 + int'(min) * 60 + int'(sec), 13 * 3600 + 5 * 60);
        for (int i = 0; i < 8 && m_ph != TICK_DIV - 1; i++) cycle("t3_align2");
        do_set(30, 0, 0);
        check_n("t3_rej_tick", int'(sec_pulse), 1);

        // 4: display mapping table
        run = 1'b0;
        foreach (tbl[i]) begin
            do_set(tbl[i].h, 0, 0);
            mode_12h = tbl[i].m12;
            #1;
            check_n("t4_disp", int'(hour_disp), tbl[i].disp);
            check_n("t4_pm", int'(pm), int'(tbl[i].pm));
        end
        mode_12h = 1'b0;

        // 5: alarm via tick fires once; direct load does not
        run = 1'b1;
        alm_h = 5'd7; alm_m = 6'd30; alm_wr = 1'b1; alm_en = 1'b1;
        cycle("t5_alm_wr");
        do_set(7, 29, 59);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cycle("t5_tick");
            cnt += int'(alarm_hit);
        end
        check_n("t5_hit_cnt", cnt, 1);
        do_set(7, 30, 0);
        cnt = int'(alarm_hit);
        for (int i = 0; i < 3; i++) begin
            cycle("t5_direct");
            cnt += int'(alarm_hit);
        end
        check_n("t5_no_hit", cnt, 0);

        // 6: pause holds time and prescaler, then async reset mid-second
        cycle("t6_pre");
        run = 1'b0;
        snap = m_tod;
        for (int i = 0; i < 100; i++) cycle("t6_pause");
        check_n("t6_frozen", int'(hour) * 3600 + int'(min) * 60 + int'(sec), snap);
        run = 1'b1;
        for (int i = 0; i < 6; i++) cycle("t6_resume");
        #3;
        rst_n = 1'b0;
        mode_12h = 1'b1;
        #1;
        model_reset();
        check("t6_async_rst", dut_vec, model_out());
        @(posedge clk);
        #1;
        check("t6_rst_hold", dut_vec, model_out());
        rst_n = 1'b1;
        mode_12h = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            run = ($urandom_range(0, 9) != 0);
            mode_12h = $urandom_range(0, 1) == 1;
            alm_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) begin
                set_h = HW'($urandom_range(0, 25));
                set_m = 6'($urandom_range(0, 61));
                set_s = 6'($urandom_range(50, 61));
                set_en = 1'b1;
            end
            if ($urandom_range(0, 49) == 0) begin
                alm_h = HW'(m_tod / 3600);
                alm_m = 6'($urandom_range(0, 63));
                alm_wr = 1'b1;
            end
            cycle("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
